// File: rtl/sar_adc_pkg.sv
// Shared types and helpers for the SAR ADC sequencer.
package sar_adc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        CONVERT = 2'd2
    } sar_seq_state_t;

    localparam int OVERRUN_W = 8;

    // Add 0..2 to the overrun counter, clamping at all-ones.
    function automatic logic [OVERRUN_W-1:0] sat_add(input logic [OVERRUN_W-1:0] base,
                                                     input logic [1:0]           inc);
        logic [OVERRUN_W:0] sum;
        sum = {1'b0, base} + {{(OVERRUN_W-1){1'b0}}, inc};
        return sum[OVERRUN_W] ? {OVERRUN_W{1'b1}} : sum[OVERRUN_W-1:0];
    endfunction

endpackage

// File: rtl/sar_period_timer.sv
// Period timer: turns a level enable into a single-cycle registered trigger
// every SAMPLE_PERIOD clocks. The count is held at zero while disabled so the
// first trigger after enable rises always lands a full period later.
module sar_period_timer
    import sar_adc_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 1000
)(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic trigger
);

    localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_PERIOD - 1);

    logic [CNT_W-1:0] count;

    // Up-count while enabled, wrap at the terminal count and register the pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            trigger <= 1'b0;
        end else begin
            trigger <= enable && (count == LAST);
            if (!enable || (count == LAST)) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sar_adc_sequencer.sv
// SAR ADC sequencer: issues periodic hold requests, waits for end of
// conversion and parks the result in a single-entry valid/ready buffer.
// Dropped triggers and dropped samples are counted; a missing eoc raises a
// sticky timeout flag.
//
// state   | meaning
// IDLE    | waiting for a period trigger
// HOLD    | adc_hold_digital high for HOLD_CYCLES clocks
// CONVERT | waiting for an adc_eoc rising edge, bounded by TIMEOUT_CYCLES
module sar_adc_sequencer
    import sar_adc_pkg::*;
#(
    parameter int N_BITS         = 10,
    parameter int SAMPLE_PERIOD  = 1000,
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 64
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 adc_hold_digital,
    input  logic                 adc_eoc,
    input  logic [N_BITS-1:0]    adc_result_digital,
    output logic [N_BITS-1:0]    sample_data,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 busy,
    output logic [OVERRUN_W-1:0] overrun_count,
    output logic                 timeout_flag
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int PH_W   = (HOLD_W > TO_W) ? HOLD_W : TO_W;
    localparam logic [PH_W-1:0] HOLD_LOAD = PH_W'(HOLD_CYCLES - 1);
    localparam logic [PH_W-1:0] TO_LOAD   = PH_W'(TIMEOUT_CYCLES - 1);

    sar_seq_state_t  state;
    sar_seq_state_t  state_nxt;
    logic            trigger;
    logic            eoc_q;
    logic [PH_W-1:0] phase_cnt;
    logic            cnt_done;
    logic            eoc_rise;
    logic            capture;
    logic            timeout;
    logic            trig_drop;
    logic            samp_drop;
    logic            accept;
    logic            hold_nxt;
    logic            busy_nxt;

    sar_period_timer #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .trigger(trigger)
    );

    assign cnt_done  = (phase_cnt == '0);
    assign eoc_rise  = adc_eoc && !eoc_q;
    assign capture   = (state == CONVERT) && eoc_rise;
    // An eoc edge on the last allowed cycle still counts as a completed conversion.
    assign timeout   = (state == CONVERT) && !eoc_rise && cnt_done;
    assign trig_drop = trigger && (state != IDLE);
    assign accept    = !sample_valid || sample_ready;
    assign samp_drop = capture && !accept;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger)              state_nxt = HOLD;
            HOLD:    if (cnt_done)             state_nxt = CONVERT;
            CONVERT: if (eoc_rise || cnt_done) state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it.
    always_comb begin
        hold_nxt = (state_nxt == HOLD);
        busy_nxt = (state_nxt != IDLE);
    end

    // Shared down-counter: hold length in HOLD, remaining wait budget in CONVERT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_cnt <= '0;
        end else if ((state == IDLE) && trigger) begin
            phase_cnt <= HOLD_LOAD;
        end else if ((state == HOLD) && cnt_done) begin
            phase_cnt <= TO_LOAD;
        end else if (!cnt_done) begin
            phase_cnt <= phase_cnt - 1'b1;
        end
    end

    // Registered control outputs, eoc history and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adc_hold_digital <= 1'b0;
            busy             <= 1'b0;
            eoc_q            <= 1'b0;
            timeout_flag     <= 1'b0;
            overrun_count    <= '0;
        end else begin
            adc_hold_digital <= hold_nxt;
            busy             <= busy_nxt;
            eoc_q            <= adc_eoc;
            if (timeout) begin
                timeout_flag <= 1'b1;
            end
            overrun_count <= sat_add(overrun_count, {1'b0, trig_drop} + {1'b0, samp_drop});
        end
    end

    // Single-entry output buffer; a capture may refill it on the same edge it drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else if (capture && accept) begin
            sample_data  <= adc_result_digital;
            sample_valid <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Directed bench for sar_adc_sequencer. Instance dut uses the common test
// parameters (period 20, hold 3, timeout 16). Instance dut_ovr uses a longer
// timeout so that a slow eoc (25 cycles) keeps it busy across a trigger.
module tb_sar_adc_sequencer;
    import sar_adc_pkg::*;

    localparam int NB = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 enable;
    logic                 sample_ready;
    logic                 adc_hold_digital;
    logic                 adc_eoc;
    logic                 model_eoc;
    logic                 eoc_force;
    logic [NB-1:0]        adc_result_digital;
    logic [NB-1:0]        sample_data;
    logic                 sample_valid;
    logic                 busy;
    logic [OVERRUN_W-1:0] overrun_count;
    logic                 timeout_flag;

    logic                 enable2;
    logic                 sample_ready2;
    logic                 hold2;
    logic                 eoc2;
    logic [NB-1:0]        result2;
    logic [NB-1:0]        data2;
    logic                 valid2;
    logic                 busy2;
    logic [OVERRUN_W-1:0] ovr2;
    logic                 tflag2;

    logic                 mute;
    logic [NB-1:0]        next_result;
    logic [NB-1:0]        step;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    logic [NB-1:0] exp_q[$];

    assign adc_eoc = model_eoc | eoc_force;

    sar_adc_sequencer #(
        .N_BITS(NB), .SAMPLE_PERIOD(20), .HOLD_CYCLES(3), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .adc_hold_digital  (adc_hold_digital),
        .adc_eoc           (adc_eoc),
        .adc_result_digital(adc_result_digital),
        .sample_data       (sample_data),
        .sample_valid      (sample_valid),
        .sample_ready      (sample_ready),
        .busy              (busy),
        .overrun_count     (overrun_count),
        .timeout_flag      (timeout_flag)
    );

    sar_adc_sequencer #(
        .N_BITS(NB), .SAMPLE_PERIOD(20), .HOLD_CYCLES(3), .TIMEOUT_CYCLES(40)
    ) dut_ovr (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable2),
        .adc_hold_digital  (hold2),
        .adc_eoc           (eoc2),
        .adc_result_digital(result2),
        .sample_data       (data2),
        .sample_valid      (valid2),
        .sample_ready      (sample_ready2),
        .busy              (busy2),
        .overrun_count     (ovr2),
        .timeout_flag      (tflag2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h at t=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic wait_to(input int n);
        while (t < n) tick();
    endtask

    // ADC model for dut: eoc rises 10 cycles after hold falls, high for 2 cycles.
    initial begin
        int   cd;
        int   eh;
        logic hp;
        cd = 0;
        eh = 0;
        hp = 1'b0;
        model_eoc = 1'b0;
        adc_result_digital = '0;
        forever begin
            @(posedge clk);
            #1;
            if (eh > 0) begin
                eh--;
                if (eh == 0) model_eoc = 1'b0;
            end
            if (hp && !adc_hold_digital) begin
                cd = 10;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0 && !mute) begin
                    model_eoc = 1'b1;
                    adc_result_digital = next_result;
                    next_result = next_result + step;
                    eh = 2;
                end
            end
            hp = adc_hold_digital;
        end
    end

    // ADC model for dut_ovr: eoc rises 25 cycles after hold falls.
    initial begin
        int   cd;
        int   eh;
        logic hp;
        cd = 0;
        eh = 0;
        hp = 1'b0;
        eoc2 = 1'b0;
        result2 = 10'h2A5;
        forever begin
            @(posedge clk);
            #1;
            if (eh > 0) begin
                eh--;
                if (eh == 0) eoc2 = 1'b0;
            end
            if (hp && !hold2) begin
                cd = 25;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    eoc2 = 1'b1;
                    eh = 2;
                end
            end
            hp = hold2;
        end
    end

    // Scoreboard: every transfer on dut must match the oldest expected sample.
    initial begin
        logic [NB-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && sample_valid && sample_ready) begin
                chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_data", 32'(sample_data), 32'(e));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        enable2 = 1'b0;
        sample_ready = 1'b1;
        sample_ready2 = 1'b1;
        eoc_force = 1'b0;
        mute = 1'b0;
        step = '0;
        next_result = 10'h2A5;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold",    32'(adc_hold_digital), 32'd0);
        chk("rst_valid",   32'(sample_valid),     32'd0);
        chk("rst_data",    32'(sample_data),      32'd0);
        chk("rst_busy",    32'(busy),             32'd0);
        chk("rst_overrun", 32'(overrun_count),    32'd0);
        chk("rst_timeout", 32'(timeout_flag),     32'd0);

        // Nominal flow: enable sampled at edge 0.
        repeat (3) exp_q.push_back(10'h2A5);
        reset = 1'b0;
        enable = 1'b1;
        t = -1;
        wait_to(19);  chk("nom_hold_pre",  32'(adc_hold_digital), 32'd0);
        wait_to(20);  chk("nom_hold_20",   32'(adc_hold_digital), 32'd1);
                      chk("nom_busy_20",   32'(busy),             32'd1);
        wait_to(22);  chk("nom_hold_22",   32'(adc_hold_digital), 32'd1);
        wait_to(23);  chk("nom_hold_23",   32'(adc_hold_digital), 32'd0);
                      chk("nom_busy_conv", 32'(busy),             32'd1);
        wait_to(33);  chk("nom_valid_33",  32'(sample_valid),     32'd0);
        wait_to(34);  chk("nom_valid_34",  32'(sample_valid),     32'd1);
                      chk("nom_data_34",   32'(sample_data),      32'h2A5);
                      chk("nom_busy_34",   32'(busy),             32'd0);
        wait_to(35);  chk("nom_valid_35",  32'(sample_valid),     32'd0);
        wait_to(40);  chk("nom_hold_40",   32'(adc_hold_digital), 32'd1);
        wait_to(54);  chk("nom_valid_54",  32'(sample_valid),     32'd1);
        wait_to(60);  chk("nom_hold_60",   32'(adc_hold_digital), 32'd1);
        wait_to(75);  chk("nom_overrun",   32'(overrun_count),    32'd0);

        // Backpressure: 100 is held, 101 and 102 are dropped.
        wait_to(80);
        sample_ready = 1'b0;
        next_result = 10'd100;
        step = 10'd1;
        exp_q.push_back(10'd100);
        wait_to(114); chk("bp_overrun_1", 32'(overrun_count), 32'd1);
        wait_to(135); chk("bp_overrun_2", 32'(overrun_count), 32'd2);
                      chk("bp_valid",     32'(sample_valid),  32'd1);
                      chk("bp_data",      32'(sample_data),   32'd100);
        wait_to(140);
        sample_ready = 1'b1;
        exp_q.push_back(10'd103);
        wait_to(141); chk("bp_drained",   32'(sample_valid),  32'd0);
        wait_to(154); chk("bp_next_data", 32'(sample_data),   32'd103);

        // Timeout: CONVERT entered at edge 163, no eoc.
        wait_to(156);
        mute = 1'b1;
        wait_to(178); chk("to_flag_pre",  32'(timeout_flag), 32'd0);
                      chk("to_busy_pre",  32'(busy),         32'd1);
        wait_to(179); chk("to_flag",      32'(timeout_flag), 32'd1);
                      chk("to_busy",      32'(busy),         32'd0);
                      chk("to_no_valid",  32'(sample_valid), 32'd0);
        wait_to(180); chk("to_next_hold", 32'(adc_hold_digital), 32'd1);
        mute = 1'b0;
        exp_q.push_back(10'd104);
        wait_to(194); chk("to_next_data", 32'(sample_data), 32'd104);

        // eoc already high on CONVERT entry must fall and rise again.
        // The result bus still carries 104 from the previous conversion.
        wait_to(196);
        mute = 1'b1;
        wait_to(199);
        eoc_force = 1'b1;
        exp_q.push_back(10'd104);
        wait_to(203); chk("pre_busy",    32'(busy),         32'd1);
        wait_to(208);
        eoc_force = 1'b0;
        wait_to(210); chk("pre_no_cap",  32'(sample_valid), 32'd0);
                      chk("pre_waiting", 32'(busy),         32'd1);
        eoc_force = 1'b1;
        wait_to(211); chk("pre_cap",     32'(sample_valid), 32'd1);
                      chk("pre_idle",    32'(busy),         32'd0);
                      chk("to_sticky",   32'(timeout_flag), 32'd1);
        eoc_force = 1'b0;

        // Asynchronous reset while hold is high.
        wait_to(220); chk("ar_hold_pre", 32'(adc_hold_digital), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_hold",    32'(adc_hold_digital), 32'd0);
        chk("ar_busy",    32'(busy),             32'd0);
        chk("ar_valid",   32'(sample_valid),     32'd0);
        chk("ar_data",    32'(sample_data),      32'd0);
        chk("ar_overrun", 32'(overrun_count),    32'd0);
        chk("ar_timeout", 32'(timeout_flag),     32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        t = -1;
        wait_to(15);
        mute = 1'b0;
        exp_q.push_back(10'd105);
        wait_to(19);  chk("ar_hold_19", 32'(adc_hold_digital), 32'd0);
        wait_to(20);  chk("ar_hold_20", 32'(adc_hold_digital), 32'd1);

        // enable low mid-conversion: the conversion finishes, nothing new starts.
        wait_to(25);
        enable = 1'b0;
        wait_to(34);  chk("dis_data",   32'(sample_data),      32'd105);
                      chk("dis_valid",  32'(sample_valid),     32'd1);
        wait_to(40);  chk("dis_hold",   32'(adc_hold_digital), 32'd0);
                      chk("dis_busy",   32'(busy),             32'd0);

        // Trigger overrun on dut_ovr: one dropped trigger every 40 cycles.
        enable2 = 1'b1;
        t = -1;
        wait_to(39);    chk("ov_cnt_39",  32'(ovr2),   32'd0);
        wait_to(40);    chk("ov_cnt_40",  32'(ovr2),   32'd1);
                        chk("ov_busy_40", 32'(busy2),  32'd1);
        wait_to(49);    chk("ov_valid",   32'(valid2), 32'd1);
                        chk("ov_data",    32'(data2),  32'h2A5);
                        chk("ov_idle",    32'(busy2),  32'd0);
        wait_to(60);    chk("ov_hold_60", 32'(hold2),  32'd1);
        wait_to(80);    chk("ov_cnt_80",  32'(ovr2),   32'd2);
        wait_to(10199); chk("ov_cnt_254", 32'(ovr2),   32'd254);
        wait_to(10200); chk("ov_cnt_255", 32'(ovr2),   32'd255);
        wait_to(10400); chk("ov_sat",     32'(ovr2),   32'd255);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
